// File: rtl/packet_dispatcher_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding one packet dispatcher from PORT_COUNT AXI-Stream ports.
// Optional macro ARB_PRIORITY_PORT0_EN gives port 0 strict priority over the round-robin ports.
module packet_dispatcher_ingress_arbiter #(
  parameter int PORT_COUNT      = 4,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int SEL_WIDTH       = $clog2(PORT_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORT_COUNT*AXIS_DATA_WIDTH-1:0] s_axis_arb_tdata,
  input  logic [PORT_COUNT*AXIS_KEEP_WIDTH-1:0] s_axis_arb_tkeep,
  input  logic [PORT_COUNT-1:0]                 s_axis_arb_tvalid,
  input  logic [PORT_COUNT-1:0]                 s_axis_arb_tlast,
  output logic [PORT_COUNT-1:0]                 s_axis_arb_tready,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_arb_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_arb_tkeep,
  output logic                                  m_axis_arb_tvalid,
  output logic                                  m_axis_arb_tlast,
  input  logic                                  m_axis_arb_tready,
  output logic [SEL_WIDTH-1:0]                  m_axis_arb_tid,
  input  logic                                  enable_arb,
  input  logic                                  rst_packet_counter,
  output logic [31:0]                           packet_counter
);

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_FORWARD = 1'b1
  } arb_state_t;

  arb_state_t           r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0] r_grant, w_grant_nxt;
  logic [SEL_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [SEL_WIDTH-1:0] w_pick, w_grant_inc;
  logic                 w_found, w_pkt_done;
  logic [31:0]          r_packet_counter;
  int                   w_idx;
`ifdef ARB_PRIORITY_PORT0_EN
  int                   w_base;
`endif

  // Scan for the first valid port starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = 0;
`ifdef ARB_PRIORITY_PORT0_EN
    w_base = (r_rr_ptr == '0) ? 1 : int'(r_rr_ptr);
    if (s_axis_arb_tvalid[0]) begin
      w_found = 1'b1;
      w_pick  = '0;
    end else begin
      for (int k = 0; k < PORT_COUNT-1; k++) begin
        w_idx = w_base + k;
        if (w_idx >= PORT_COUNT) w_idx = w_idx - (PORT_COUNT-1);
        if (!w_found && s_axis_arb_tvalid[w_idx]) begin
          w_found = 1'b1;
          w_pick  = SEL_WIDTH'(w_idx);
        end
      end
    end
`else
    for (int k = 0; k < PORT_COUNT; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= PORT_COUNT) w_idx = w_idx - PORT_COUNT;
      if (!w_found && s_axis_arb_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = SEL_WIDTH'(w_idx);
      end
    end
`endif
  end

  assign w_grant_inc = (r_grant == SEL_WIDTH'(PORT_COUNT-1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_pkt_done        = 1'b0;
    s_axis_arb_tready = '0;
    m_axis_arb_tvalid = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (enable_arb && w_found) begin
          w_state_nxt = ARB_FORWARD;
          w_grant_nxt = w_pick;
        end
      end
      ARB_FORWARD: begin
        s_axis_arb_tready[r_grant] = m_axis_arb_tready;
        m_axis_arb_tvalid          = s_axis_arb_tvalid[r_grant];
        if (s_axis_arb_tvalid[r_grant] && m_axis_arb_tready && s_axis_arb_tlast[r_grant]) begin
          w_state_nxt = ARB_IDLE;
          w_pkt_done  = 1'b1;
`ifdef ARB_PRIORITY_PORT0_EN
          // Port 0 sits outside the rotation, so its grants leave the pointer alone.
          if (r_grant != '0) w_rr_ptr_nxt = w_grant_inc;
`else
          w_rr_ptr_nxt = w_grant_inc;
`endif
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ARB_IDLE;
      r_grant          <= '0;
      r_rr_ptr         <= '0;
      r_packet_counter <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (rst_packet_counter)
        r_packet_counter <= '0;
      else if (w_pkt_done)
        r_packet_counter <= r_packet_counter + 32'd1;
    end
  end

  // The mux follows the grant even in idle, where the outputs are don't-care.
  assign m_axis_arb_tdata = s_axis_arb_tdata[r_grant*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign m_axis_arb_tkeep = s_axis_arb_tkeep[r_grant*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
  assign m_axis_arb_tlast = s_axis_arb_tlast[r_grant];
  assign m_axis_arb_tid   = r_grant;
  assign packet_counter   = r_packet_counter;

endmodule

// File: tb/tb_packet_dispatcher_ingress_arbiter.sv
// Self-checking bench for packet_dispatcher_ingress_arbiter: packet-level model plus directed scenarios.
module tb_packet_dispatcher_ingress_arbiter;
  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [P*DW-1:0] s_tdata;
  logic [P*KW-1:0] s_tkeep;
  logic [P-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast, m_tready;
  logic [SW-1:0]   m_tid;
  logic            enable_arb, rst_cnt;
  logic [31:0]     pkt_cnt;

  packet_dispatcher_ingress_arbiter #(
    .PORT_COUNT(P), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_arb_tdata(s_tdata), .s_axis_arb_tkeep(s_tkeep),
    .s_axis_arb_tvalid(s_tvalid), .s_axis_arb_tlast(s_tlast), .s_axis_arb_tready(s_tready),
    .m_axis_arb_tdata(m_tdata), .m_axis_arb_tkeep(m_tkeep), .m_axis_arb_tvalid(m_tvalid),
    .m_axis_arb_tlast(m_tlast), .m_axis_arb_tready(m_tready), .m_axis_arb_tid(m_tid),
    .enable_arb(enable_arb), .rst_packet_counter(rst_cnt), .packet_counter(pkt_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-port source queues of {last, data}; hs marks beats taken at the coming edge.
  logic [64:0] q [P][$];
  logic [P-1:0] gap = '0;
  logic [P-1:0] hs  = '0;

  // Packet-level model: owning port (-1 = none), next-in-line pointer, packet count.
  int          m_owner = -1;
  int          m_rr    = 0;
  logic [31:0] m_cnt   = '0;
  logic        m_done;
  logic [P-1:0] exp_rdy;
  logic        exp_valid;

  // Beats the DUT actually delivered downstream.
  int          dl_tid[$];
  logic [63:0] dl_data[$];
  logic        dl_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [P-1:0] v, input int rr);
`ifdef ARB_PRIORITY_PORT0_EN
    int start;
    if (v[0]) return 0;
    start = (rr == 0) ? 1 : rr;
    for (int k = 0; k < P-1; k++) begin
      int p;
      p = 1 + (start - 1 + k) % (P-1);
      if (v[p]) return p;
    end
`else
    for (int k = 0; k < P; k++) begin
      int p;
      p = (rr + k) % P;
      if (v[p]) return p;
    end
`endif
    return -1;
  endfunction

  // Compare DUT against model every cycle, then advance the model to the next edge.
  initial forever begin
    @(negedge clk);
    exp_valid = (m_owner >= 0) ? s_tvalid[m_owner] : 1'b0;
    exp_rdy   = '0;
    if (m_owner >= 0 && m_tready) exp_rdy[m_owner] = 1'b1;
    chk("tvalid", {63'd0, m_tvalid}, {63'd0, exp_valid});
    chk("tready", {60'd0, s_tready}, {60'd0, exp_rdy});
    chk("counter", {32'd0, pkt_cnt}, {32'd0, m_cnt});
    if (exp_valid) begin
      chk("tdata", m_tdata, s_tdata[m_owner*DW +: DW]);
      chk("tkeep", {56'd0, m_tkeep}, {56'd0, s_tkeep[m_owner*KW +: KW]});
      chk("tlast", {63'd0, m_tlast}, {63'd0, s_tlast[m_owner]});
      chk("tid", {62'd0, m_tid}, 64'(m_owner));
    end
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      dl_tid.push_back(int'(m_tid));
      dl_data.push_back(m_tdata);
      dl_last.push_back(m_tlast);
    end
    m_done = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_rr    = 0;
      m_cnt   = '0;
    end else begin
      if (m_owner >= 0) begin
        if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) begin
          m_done = 1'b1;
`ifdef ARB_PRIORITY_PORT0_EN
          if (m_owner != 0) m_rr = (m_owner + 1) % P;
`else
          m_rr = (m_owner + 1) % P;
`endif
          m_owner = -1;
        end
      end else if (enable_arb && s_tvalid != '0) begin
        m_owner = pick(s_tvalid, m_rr);
      end
      if (rst_cnt) m_cnt = '0;
      else if (m_done) m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic drive();
    for (int i = 0; i < P; i++) begin
      if (q[i].size() > 0 && !gap[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = q[i][0][63:0];
        s_tlast[i]           = q[i][0][64];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = 64'hDEAD_0000_0000_0000 | 64'(i);
        s_tlast[i]           = 1'b0;
      end
      s_tkeep[i*KW +: KW] = 8'hF0 | 8'(i);
    end
  endtask

  task automatic half();
    drive();
    @(negedge clk);
    #1;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++)
      if (hs[i]) void'(q[i].pop_front());
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  function automatic logic any_pending();
    for (int i = 0; i < P; i++)
      if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_empty(input int maxc, output int cycles);
    cycles = 0;
    while (any_pending() && cycles < maxc) begin
      tick();
      cycles++;
    end
    chk("drain", {63'd0, any_pending()}, 64'd0);
  endtask

  task automatic push_beat(input int port, input logic [63:0] d, input logic last);
    q[port].push_back({last, d});
  endtask

  task automatic push_pkt(input int port, input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) push_beat(port, base + 64'(k), (k == n-1));
  endtask

  task automatic clear_log();
    dl_tid.delete();
    dl_data.delete();
    dl_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int prev_last;
    int starts[$];
    int exp_order[8];
    logic [63:0] e1[3];
    logic [63:0] e3[5];
    int t3[5];

    rst = 1'b1; enable_arb = 1'b1; m_tready = 1'b1; rst_cnt = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
    drive();
    do_reset();

    half();
    chk("rst_tid", {62'd0, m_tid}, 64'd0);
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tready", {60'd0, s_tready}, 64'd0);
    chk("rst_counter", {32'd0, pkt_cnt}, 64'd0);
    fin();

    // Single port 2, three beats.
    push_beat(2, 64'h11, 1'b0);
    push_beat(2, 64'h22, 1'b0);
    push_beat(2, 64'h33, 1'b1);
    half();
    chk("t1_idle_first", {63'd0, m_tvalid}, 64'd0);
    fin();
    half();
    chk("t1_valid", {63'd0, m_tvalid}, 64'd1);
    chk("t1_tid", {62'd0, m_tid}, 64'd2);
    chk("t1_data0", m_tdata, 64'h11);
    fin();
    run_empty(20, c);
    half();
    chk("t1_count", {32'd0, pkt_cnt}, 64'd1);
    fin();
    e1 = '{64'h11, 64'h22, 64'h33};
    chk("t1_nbeats", 64'(dl_tid.size()), 64'd3);
    for (int k = 0; k < 3 && k < dl_tid.size(); k++) begin
      chk("t1_beat_data", dl_data[k], e1[k]);
      chk("t1_beat_tid", 64'(dl_tid[k]), 64'd2);
      chk("t1_beat_last", {63'd0, dl_last[k]}, (k == 2) ? 64'd1 : 64'd0);
    end

    // Fairness: every port holds two 2-beat packets.
    do_reset();
    clear_log();
    for (int p = 0; p < P; p++) begin
      push_pkt(p, 2, 64'h100 * 64'(p) + 64'h10);
      push_pkt(p, 2, 64'h100 * 64'(p) + 64'h20);
    end
    run_empty(100, c);
    chk("t2_cycles", 64'(c), 64'd24);
    half();
    chk("t2_count", {32'd0, pkt_cnt}, 64'd8);
    fin();
`ifdef ARB_PRIORITY_PORT0_EN
    exp_order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    prev_last = 1;
    for (int k = 0; k < dl_tid.size(); k++) begin
      if (prev_last != 0) starts.push_back(dl_tid[k]);
      prev_last = int'(dl_last[k]);
    end
    chk("t2_npkts", 64'(starts.size()), 64'd8);
    for (int k = 0; k < 8 && k < starts.size(); k++)
      chk("t2_order", 64'(starts[k]), 64'(exp_order[k]));

    // Backpressure with ready toggling plus one source gap.
    clear_log();
    push_pkt(1, 4, 64'hA1);
    push_beat(3, 64'hC3, 1'b1);
    c = 0;
    while (any_pending() && c < 40) begin
      m_tready = (c % 2 == 0);
      gap[1]   = (c == 4);
      tick();
      c++;
    end
    chk("t3_drain", {63'd0, any_pending()}, 64'd0);
    m_tready = 1'b1;
    gap      = '0;
    e3 = '{64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hC3};
    t3 = '{1, 1, 1, 1, 3};
    chk("t3_nbeats", 64'(dl_tid.size()), 64'd5);
    for (int k = 0; k < 5 && k < dl_tid.size(); k++) begin
      chk("t3_beat_data", dl_data[k], e3[k]);
      chk("t3_beat_tid", 64'(dl_tid[k]), 64'(t3[k]));
    end

    // Enable gating mid-packet on port 1 while port 3 waits.
    push_pkt(1, 4, 64'hB1);
    tick();
    tick();
    enable_arb = 1'b0;
    push_beat(3, 64'hD1, 1'b0);
    push_beat(3, 64'hD2, 1'b1);
    tick();
    tick();
    tick();
    chk("t4_port1_done", 64'(q[1].size()), 64'd0);
    for (int k = 0; k < 3; k++) begin
      half();
      chk("t4_gated", {63'd0, m_tvalid}, 64'd0);
      fin();
    end
    enable_arb = 1'b1;
    half();
    chk("t4_reenable_idle", {63'd0, m_tvalid}, 64'd0);
    fin();
    half();
    chk("t4_grant_valid", {63'd0, m_tvalid}, 64'd1);
    chk("t4_grant_tid", {62'd0, m_tid}, 64'd3);
    chk("t4_grant_data", m_tdata, 64'hD1);
    fin();
    run_empty(10, c);

    // Counter wrap from all-ones.
    force dut.r_packet_counter = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    push_beat(0, 64'hE0, 1'b1);
    half();
    release dut.r_packet_counter;
    fin();
    tick();
    half();
    chk("t5_wrap", {32'd0, pkt_cnt}, 64'd0);
    fin();

    // Clear coinciding with an increment.
    push_pkt(2, 2, 64'h50);
    run_empty(10, c);
    half();
    chk("t5_count1", {32'd0, pkt_cnt}, 64'd1);
    fin();
    push_pkt(3, 2, 64'h70);
    tick();
    tick();
    rst_cnt = 1'b1;
    tick();
    rst_cnt = 1'b0;
    half();
    chk("t5_clear_wins", {32'd0, pkt_cnt}, 64'd0);
    fin();

    // Reset mid-packet with the pointer parked away from port 0.
    push_beat(1, 64'h61, 1'b1);
    run_empty(10, c);
    push_pkt(0, 4, 64'hC1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q[0].delete();
    push_pkt(0, 2, 64'hD0);
    push_pkt(3, 2, 64'hE0);
    half();
    chk("t6_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("t6_tready", {60'd0, s_tready}, 64'd0);
    chk("t6_count", {32'd0, pkt_cnt}, 64'd0);
    fin();
    half();
    chk("t6_regrant_valid", {63'd0, m_tvalid}, 64'd1);
    chk("t6_regrant_tid", {62'd0, m_tid}, 64'd0);
    chk("t6_regrant_data", m_tdata, 64'hD0);
    fin();
    run_empty(20, c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
